// File: rtl/seq_det_pkg.sv
// Shared types for the serial "101" detector and its word controller.
// Holds the detector/controller state enums, the pattern length and the detector next-state function.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    localparam int PATTERN_LEN = 3;

    // S2 means "10" seen; S3 means a "101" just completed (its trailing 1 can start a new match).
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S1 : S2;
            S2:      n = b ? S3 : S0;
            S3:      n = b ? S1 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Overlapping serial "101" detector with a Mealy hit output.
// State only moves when en is high; clr returns it to S0.
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic bit_in,
    output logic hit
);

    det_state_t state_q;
    det_state_t state_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            state_d = det_next(state_q, bit_in);
        end
    end

    assign hit = en && (state_q == S2) && bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word controller: accepts a word, feeds it MSB first into seq_det_core, and reports the hit mask and count.
// Optional macro SEQ_DET_CTRL_STATS_EN adds a saturating 16-bit total_hits counter.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic [CNT_W-1:0] out_count
`ifdef SEQ_DET_CTRL_STATS_EN
    ,
    output logic [15:0]      total_hits
`endif
);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             core_en;
    logic             core_clr;
    logic             hit;

    // One extra SHIFT cycle after the last bit (bit_cnt_q == 0) before REPORT.
    assign core_en  = (state_q == SHIFT) && (bit_cnt_q != '0);
    assign core_clr = (state_q == IDLE) && flush;

    seq_det_core u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (core_en),
        .clr    (core_clr),
        .bit_in (data_q[WIDTH-1]),
        .hit    (hit)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        count_d   = count_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d    = in_data;
                    mask_d    = '0;
                    count_d   = '0;
                    bit_cnt_d = CNT_W'(WIDTH);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    // Mask shifts in alongside the data so bit i lands where in_data[i] came from.
                    data_d    = {data_q[WIDTH-2:0], 1'b0};
                    mask_d    = {mask_q[WIDTH-2:0], hit};
                    count_d   = count_q + CNT_W'(hit);
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end else begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            count_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == REPORT);
    assign out_mask  = mask_q;
    assign out_count = count_q;

`ifdef SEQ_DET_CTRL_STATS_EN
    logic [15:0] total_hits_q, total_hits_d;
    logic [16:0] total_sum;

    always_comb begin
        total_sum    = {1'b0, total_hits_q} + 17'(count_q);
        total_hits_d = total_hits_q;
        if ((state_q == REPORT) && out_ready) begin
            total_hits_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_hits_q <= '0;
        end else begin
            total_hits_q <= total_hits_d;
        end
    end

    assign total_hits = total_hits_q;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized self-checking bench for seq_det_ctrl against a bit-history "101" model.
// Define SEQ_DET_CTRL_STATS_EN to also check total_hits.
module tb_seq_det_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_mask;
    logic [CNT_W-1:0] out_count;
`ifdef SEQ_DET_CTRL_STATS_EN
    logic [15:0]      total_hits;
    int unsigned      exp_total = 0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference: every bit ever fed since the last reset/flush; a hit is "last three bits are 1,0,1".
    bit hist[$];

    always #5 clk = ~clk;

    seq_det_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count)
`ifdef SEQ_DET_CTRL_STATS_EN
        ,
        .total_hits(total_hits)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_feed(input bit b);
        int n;
        hist.push_back(b);
        n = hist.size();
        return (n >= 3) && hist[n-3] && !hist[n-2] && hist[n-1];
    endfunction

    task automatic model_expect(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] m,
                                output int c);
        m = '0;
        c = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (model_feed(d[i])) begin
                m[i] = 1'b1;
                c++;
            end
        end
    endtask

    task automatic pulse_reset();
        #3 rst = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_mask", out_mask, 0);
        check_eq("rst_out_count", out_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
`ifdef SEQ_DET_CTRL_STATS_EN
        exp_total = 0;
        check_eq("rst_total_hits", total_hits, 0);
`endif
    endtask

    task automatic wait_in_ready();
        int cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 0, 1);
    endtask

    task automatic idle_flush();
        wait_in_ready();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        hist.delete();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input bit fl, input int hold,
                             output logic [WIDTH-1:0] got_mask, output int got_count);
        logic [WIDTH-1:0] exp_mask;
        int               exp_count;
        int               lat;
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        if (fl) hist.delete();
        model_expect(d, exp_mask, exp_count);
        check_eq("busy_in_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, WIDTH + 1);
        check_eq("mask", out_mask, exp_mask);
        check_eq("count", out_count, exp_count);
        got_mask  = out_mask;
        got_count = int'(out_count);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_mask", out_mask, exp_mask);
            check_eq("hold_count", out_count, exp_count);
            check_eq("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", out_valid, 0);
        check_eq("post_hs_in_ready", in_ready, 1);
`ifdef SEQ_DET_CTRL_STATS_EN
        exp_total = exp_total + exp_count;
        if (exp_total > 16'hFFFF) exp_total = 16'hFFFF;
        check_eq("total_hits", total_hits, exp_total);
`endif
        $display("word %b flush %0d hold %0d -> mask %b count %0d", d, fl, hold, got_mask,
                 got_count);
    endtask

    initial begin
        logic [WIDTH-1:0] m;
        int               c;
        int               seen;

        pulse_reset();

        // Two hits inside one word
        send_word(8'b1010_1000, 1'b0, 0, m, c);
        check_eq("d030_mask", m, 8'b0010_1000);
        check_eq("d030_count", c, 2);

        // Pattern spanning a word boundary, then the same with a flush in between
        pulse_reset();
        send_word(8'b0000_0010, 1'b0, 0, m, c);
        send_word(8'b1000_0000, 1'b0, 0, m, c);
        check_eq("d031_span_mask", m, 8'b1000_0000);
        check_eq("d031_span_count", c, 1);
        send_word(8'b0000_0010, 1'b0, 0, m, c);
        idle_flush();
        send_word(8'b1000_0000, 1'b0, 0, m, c);
        check_eq("d031_flush_mask", m, 8'b0000_0000);
        check_eq("d031_flush_count", c, 0);
        send_word(8'b0000_0010, 1'b0, 0, m, c);
        send_word(8'b1000_0000, 1'b1, 0, m, c);
        check_eq("d031_flush_acc_mask", m, 8'b0000_0000);

        // Backpressure with a competing in_valid
        pulse_reset();
        send_word(8'b1010_1010, 1'b0, 5, m, c);
        check_eq("d032_mask", m, 8'b0010_1010);
        check_eq("d032_count", c, 3);

        // Reset in the middle of a scan
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = 8'b1111_0101;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        pulse_reset();
        seen = 0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("d033_no_valid", seen, 0);
        check_eq("d033_in_ready", in_ready, 1);
        send_word(8'b1010_0000, 1'b0, 0, m, c);
        check_eq("d033_mask", m, 8'b0010_0000);

        // Randomized traffic with occasional flush and reset
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0: pulse_reset();
                1: idle_flush();
                default: ;
            endcase
            send_word(WIDTH'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 3), m, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
